idex_stage_reg: RTL and testbench
=================================

Name: idex_stage_reg

Overview:
Parametrised ID/EX pipeline stage register for the pipelined MIPS core. It succeeds the fixed-width, always-enabled ID/EX register and adds four features:
- downstream stall (hold)
- flush (bubble insertion)
- a per-entry valid bit
- built-in load-use hazard detection, with a saturating bubble counter for performance monitoring.

It sits between decode/register-file read and the EX stage (ALU, forwarding unit).

Parameters:
DATA_WIDTH, 32, width of pc, read_data_1/2, immediate_extend
REG_ADDR_WIDTH, 5, width of register specifiers (rs, rt, rd, write_register)
ALU_CTRL_WIDTH, 4, width of alu_ctrl
JMP_WIDTH, 28, width of shifted jump target
CNT_WIDTH, 16, width of bubble counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state
stall_i  in  1  downstream stall; hold all contents
flush_i  in  1  control-flow flush; load a bubble
valid_i  in  1  ID-stage instruction valid
uses_rt_i  in  1  ID instruction reads rt as a source
ctrl_i / ctrl_o  in/out  8  {branch_ne, branch_eq, jmp, mem_to_reg, mem_write, mem_read, alu_src, reg_write}, bit 7..0
pc_i / pc_o  in/out  DATA_WIDTH  PC+4 of instruction
read_data_1_i / read_data_1_o  in/out  DATA_WIDTH  rs operand
read_data_2_i / read_data_2_o  in/out  DATA_WIDTH  rt operand
immediate_extend_i / immediate_extend_o  in/out  DATA_WIDTH  sign-extended immediate
jmp_target_i / jmp_target_o  in/out  JMP_WIDTH  shifted jump field
shamt_i / shamt_o  in/out  5  shift amount
alu_ctrl_i / alu_ctrl_o  in/out  ALU_CTRL_WIDTH  ALU operation
write_register_i / write_register_o  in/out  REG_ADDR_WIDTH  destination register
rs_i / rs_o, rt_i / rt_o, rd_i / rd_o  in/out  REG_ADDR_WIDTH  source/dest specifiers
valid_o  out  1  EX-stage entry valid
hazard_o  out  1  load-use hazard; ID and PC must hold
bubble_count_o  out  CNT_WIDTH  bubbles inserted since reset, saturating

Behaviour:
- Reset: synchronous and active-high. All registered outputs clear to 0, including valid_o and bubble_count_o.
- Latency: one cycle; a load presents the inputs on the outputs after the next rising edge.
- hazard_o is combinational from the current contents and ID inputs:
  - Condition: valid_o & ctrl_o[2] (mem_read) & valid_i & (write_register_o != 0) & ((write_register_o == rs_i) | (uses_rt_i & write_register_o == rt_i)).
  - hazard_o is reported even while stall_i=1.
- Per-edge action, strict priority:
  - 1) reset: clear everything.
  - 2) stall_i=1: hold all fields, valid_o and counter unchanged (stall wins over flush and hazard).
  - 3) flush_i=1 or hazard_o=1: load a bubble and increment the counter by 1.
  - 4) otherwise: load all inputs; valid_o <= valid_i.
- Bubble contents: ctrl_o=0, valid_o=0, and every data/specifier field 0. Contents are fully deterministic.
- Counter: bubble_count_o saturates at all-ones and never wraps. It counts only cycles that actually load a bubble.
- A bubble never raises hazard_o on the following cycle, because valid_o=0.
- A hazard persists while a stall holds the load in EX. Once the bubble is loaded, hazard_o deasserts and the ID instruction loads on the next unstalled edge.
- Register $0 destination never triggers a hazard.

Test Plan:
- Reset: reset=1 with arbitrary inputs for 2 cycles -> all outputs 0, hazard_o=0, bubble_count_o=0.
- Pass-through: valid_i=1, ctrl_i=8'h01, pc_i=32'h0040_0010, read_data_1_i=32'hDEAD_BEEF, rs_i=3 -> identical values one cycle later, valid_o=1.
- Stall: load pc=32'h100; next cycle pc_i=32'h104 with stall_i=1 for 3 cycles -> pc_o stays 32'h100; with stall_i=0, pc_o becomes 32'h104.
- Load-use: EX holds lw (ctrl_o[2]=1, write_register_o=8); ID drives rs_i=8 -> hazard_o=1 and a bubble is loaded (ctrl_o=0, valid_o=0, count=1); next cycle hazard_o=0 and the ID instruction loads. Repeat with uses_rt_i=0, rt_i=8, rs_i=9 -> hazard_o=0. Repeat with write_register_o=0 -> hazard_o=0.
- Flush priority: flush_i=1 with stall_i=1 -> hold, count unchanged; flush_i=1 with stall_i=0 -> bubble, count +1.
- Saturation: CNT_WIDTH=4, force 20 flush cycles -> bubble_count_o=4'hF.

Source files
------------

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with stall, flush, valid tracking,
// load-use hazard detection and a saturating bubble counter.
module idex_stage_reg #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int ALU_CTRL_WIDTH = 4,
   parameter int JMP_WIDTH      = 28,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      stall_i,
   input  logic                      flush_i,
   input  logic                      valid_i,
   input  logic                      uses_rt_i,
   input  logic [7:0]                ctrl_i,
   input  logic [DATA_WIDTH-1:0]     pc_i,
   input  logic [DATA_WIDTH-1:0]     read_data_1_i,
   input  logic [DATA_WIDTH-1:0]     read_data_2_i,
   input  logic [DATA_WIDTH-1:0]     immediate_extend_i,
   input  logic [JMP_WIDTH-1:0]      jmp_target_i,
   input  logic [4:0]                shamt_i,
   input  logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_i,
   input  logic [REG_ADDR_WIDTH-1:0] write_register_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs_i,
   input  logic [REG_ADDR_WIDTH-1:0] rt_i,
   input  logic [REG_ADDR_WIDTH-1:0] rd_i,
   output logic [7:0]                ctrl_o,
   output logic [DATA_WIDTH-1:0]     pc_o,
   output logic [DATA_WIDTH-1:0]     read_data_1_o,
   output logic [DATA_WIDTH-1:0]     read_data_2_o,
   output logic [DATA_WIDTH-1:0]     immediate_extend_o,
   output logic [JMP_WIDTH-1:0]      jmp_target_o,
   output logic [4:0]                shamt_o,
   output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_o,
   output logic [REG_ADDR_WIDTH-1:0] write_register_o,
   output logic [REG_ADDR_WIDTH-1:0] rs_o,
   output logic [REG_ADDR_WIDTH-1:0] rt_o,
   output logic [REG_ADDR_WIDTH-1:0] rd_o,
   output logic                      valid_o,
   output logic                      hazard_o,
   output logic [CNT_WIDTH-1:0]      bubble_count_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic wr_nz;
   logic rs_hit;
   logic rt_hit;
   logic bubble;
   logic cnt_sat;

   assign wr_nz   = |write_register_o;
   assign rs_hit  = (write_register_o == rs_i);
   assign rt_hit  = uses_rt_i & (write_register_o == rt_i);
   assign cnt_sat = &bubble_count_o;

   assign hazard_o = valid_o & ctrl_o[2] & valid_i & wr_nz
                     & (rs_hit | rt_hit);

   assign bubble = flush_i | hazard_o;

   always_ff @(posedge clk) begin
      if (reset || (!stall_i && bubble)) begin
         ctrl_o             <= '0;
         pc_o               <= '0;
         read_data_1_o      <= '0;
         read_data_2_o      <= '0;
         immediate_extend_o <= '0;
         jmp_target_o       <= '0;
         shamt_o            <= '0;
         alu_ctrl_o         <= '0;
         write_register_o   <= '0;
         rs_o               <= '0;
         rt_o               <= '0;
         rd_o               <= '0;
         valid_o            <= 1'b0;
      end else if (!stall_i) begin
         ctrl_o             <= ctrl_i;
         pc_o               <= pc_i;
         read_data_1_o      <= read_data_1_i;
         read_data_2_o      <= read_data_2_i;
         immediate_extend_o <= immediate_extend_i;
         jmp_target_o       <= jmp_target_i;
         shamt_o            <= shamt_i;
         alu_ctrl_o         <= alu_ctrl_i;
         write_register_o   <= write_register_i;
         rs_o               <= rs_i;
         rt_o               <= rt_i;
         rd_o               <= rd_i;
         valid_o            <= valid_i;
      end
   end

   // Counter only moves on edges that really insert a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         bubble_count_o <= '0;
      end else if (!stall_i && bubble && !cnt_sat) begin
         bubble_count_o <= bubble_count_o + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_idex_stage_reg.sv
// Bench for idex_stage_reg: directed steps followed by random
// traffic, compared against a behavioural model of the stage.
module tb_idex_stage_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, stall_i, flush_i, valid_i, uses_rt_i;
   logic [7:0]  ctrl_i;
   logic [31:0] pc_i, read_data_1_i, read_data_2_i, immediate_extend_i;
   logic [27:0] jmp_target_i;
   logic [4:0]  shamt_i;
   logic [3:0]  alu_ctrl_i;
   logic [4:0]  write_register_i, rs_i, rt_i, rd_i;

   logic [7:0]  ctrl_o;
   logic [31:0] pc_o, read_data_1_o, read_data_2_o, immediate_extend_o;
   logic [27:0] jmp_target_o;
   logic [4:0]  shamt_o;
   logic [3:0]  alu_ctrl_o;
   logic [4:0]  write_register_o, rs_o, rt_o, rd_o;
   logic        valid_o, hazard_o;
   logic [15:0] bubble_count_o;

   logic [7:0]  s_ctrl;
   logic [31:0] s_pc, s_rd1, s_rd2, s_imm;
   logic [27:0] s_jmp;
   logic [4:0]  s_shamt;
   logic [3:0]  s_alu;
   logic [4:0]  s_wr, s_rs, s_rt, s_rd;
   logic        s_valid, s_hazard;
   logic [3:0]  s_count;

   idex_stage_reg dut (
      .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
      .valid_i(valid_i), .uses_rt_i(uses_rt_i), .ctrl_i(ctrl_i),
      .pc_i(pc_i), .read_data_1_i(read_data_1_i),
      .read_data_2_i(read_data_2_i),
      .immediate_extend_i(immediate_extend_i),
      .jmp_target_i(jmp_target_i), .shamt_i(shamt_i),
      .alu_ctrl_i(alu_ctrl_i), .write_register_i(write_register_i),
      .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
      .ctrl_o(ctrl_o), .pc_o(pc_o), .read_data_1_o(read_data_1_o),
      .read_data_2_o(read_data_2_o),
      .immediate_extend_o(immediate_extend_o),
      .jmp_target_o(jmp_target_o), .shamt_o(shamt_o),
      .alu_ctrl_o(alu_ctrl_o), .write_register_o(write_register_o),
      .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .valid_o(valid_o),
      .hazard_o(hazard_o), .bubble_count_o(bubble_count_o)
   );

   idex_stage_reg #(.CNT_WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
      .valid_i(valid_i), .uses_rt_i(uses_rt_i), .ctrl_i(ctrl_i),
      .pc_i(pc_i), .read_data_1_i(read_data_1_i),
      .read_data_2_i(read_data_2_i),
      .immediate_extend_i(immediate_extend_i),
      .jmp_target_i(jmp_target_i), .shamt_i(shamt_i),
      .alu_ctrl_i(alu_ctrl_i), .write_register_i(write_register_i),
      .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
      .ctrl_o(s_ctrl), .pc_o(s_pc), .read_data_1_o(s_rd1),
      .read_data_2_o(s_rd2), .immediate_extend_o(s_imm),
      .jmp_target_o(s_jmp), .shamt_o(s_shamt), .alu_ctrl_o(s_alu),
      .write_register_o(s_wr), .rs_o(s_rs), .rt_o(s_rt), .rd_o(s_rd),
      .valid_o(s_valid), .hazard_o(s_hazard), .bubble_count_o(s_count)
   );

   int tests_run = 0;
   int tests_failed = 0;

   // Reference: EX entry as a record, bubble tallies as integers.
   typedef struct {
      bit          valid;
      logic [7:0]  ctrl;
      logic [31:0] pc, rd1, rd2, imm;
      logic [27:0] jmp;
      logic [4:0]  shamt;
      logic [3:0]  alu;
      logic [4:0]  wr, rs, rt, rd;
   } entry_t;

   entry_t m;
   entry_t empty_e;
   int     m_cnt;
   int     m_cnt4;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_hazard();
      bit hit;
      hit = (m.wr == rs_i) || (uses_rt_i && m.wr == rt_i);
      return m.valid && m.ctrl[2] && valid_i && (m.wr != 0) && hit;
   endfunction

   task automatic check_all();
      check("ctrl", ctrl_o, m.ctrl);
      check("valid", valid_o, m.valid);
      check("pc", pc_o, m.pc);
      check("rd1", read_data_1_o, m.rd1);
      check("rd2", read_data_2_o, m.rd2);
      check("imm", immediate_extend_o, m.imm);
      check("jmp", jmp_target_o, m.jmp);
      check("shamt", shamt_o, m.shamt);
      check("alu", alu_ctrl_o, m.alu);
      check("wr", write_register_o, m.wr);
      check("rs", rs_o, m.rs);
      check("rt", rt_o, m.rt);
      check("rd", rd_o, m.rd);
      check("count", bubble_count_o, m_cnt);
      check("count4", s_count, m_cnt4);
      check("valid4", s_valid, m.valid);
   endtask

   task automatic tick();
      bit h;
      #1;
      h = model_hazard();
      check("hazard", hazard_o, h);
      @(posedge clk);
      if (reset) begin
         m = empty_e;
         m_cnt = 0;
         m_cnt4 = 0;
      end else if (stall_i) begin
         m = m;
      end else if (flush_i || h) begin
         m = empty_e;
         m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
         m_cnt4 = (m_cnt4 + 1 > 15) ? 15 : m_cnt4 + 1;
      end else begin
         m.valid = valid_i;
         m.ctrl = ctrl_i;
         m.pc = pc_i;
         m.rd1 = read_data_1_i;
         m.rd2 = read_data_2_i;
         m.imm = immediate_extend_i;
         m.jmp = jmp_target_i;
         m.shamt = shamt_i;
         m.alu = alu_ctrl_i;
         m.wr = write_register_i;
         m.rs = rs_i;
         m.rt = rt_i;
         m.rd = rd_i;
      end
      #1;
      check_all();
   endtask

   task automatic clear_in();
      reset = 0; stall_i = 0; flush_i = 0; valid_i = 0;
      uses_rt_i = 0; ctrl_i = 0; pc_i = 0; read_data_1_i = 0;
      read_data_2_i = 0; immediate_extend_i = 0; jmp_target_i = 0;
      shamt_i = 0; alu_ctrl_i = 0; write_register_i = 0;
      rs_i = 0; rt_i = 0; rd_i = 0;
   endtask

   task automatic rand_in();
      valid_i = $urandom_range(0, 3) != 0;
      uses_rt_i = $urandom_range(0, 1) != 0;
      ctrl_i = 8'($urandom);
      pc_i = $urandom;
      read_data_1_i = $urandom;
      read_data_2_i = $urandom;
      immediate_extend_i = $urandom;
      jmp_target_i = 28'($urandom);
      shamt_i = 5'($urandom);
      alu_ctrl_i = 4'($urandom);
      write_register_i = 5'($urandom_range(0, 3));
      rs_i = 5'($urandom_range(0, 3));
      rt_i = 5'($urandom_range(0, 3));
      rd_i = 5'($urandom);
   endtask

   initial begin
      empty_e = '{default: '0};
      m = '{default: 'x};
      m_cnt = 0;
      m_cnt4 = 0;
      clear_in();

      rand_in();
      reset = 1;
      stall_i = 1;
      flush_i = 1;
      tick();
      tick();
      check("rst_pc", pc_o, 32'h0);
      check("rst_cnt", bubble_count_o, 16'h0);

      clear_in();
      valid_i = 1;
      ctrl_i = 8'h01;
      pc_i = 32'h0040_0010;
      read_data_1_i = 32'hDEAD_BEEF;
      rs_i = 5'd3;
      tick();
      check("pt_pc", pc_o, 32'h0040_0010);
      check("pt_rd1", read_data_1_o, 32'hDEAD_BEEF);
      check("pt_valid", valid_o, 1'b1);

      pc_i = 32'h100;
      tick();
      pc_i = 32'h104;
      stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_pc", pc_o, 32'h100);
      end
      stall_i = 0;
      tick();
      check("unstall_pc", pc_o, 32'h104);

      clear_in();
      valid_i = 1;
      ctrl_i = 8'h04;
      write_register_i = 5'd8;
      tick();
      ctrl_i = 8'h01;
      write_register_i = 5'd9;
      rs_i = 5'd8;
      #1;
      check("lu_hazard", hazard_o, 1'b1);
      tick();
      check("lu_ctrl", ctrl_o, 8'h00);
      check("lu_valid", valid_o, 1'b0);
      check("lu_count", bubble_count_o, 16'd1);
      tick();
      check("lu_load_rs", rs_o, 5'd8);
      check("lu_load_valid", valid_o, 1'b1);

      ctrl_i = 8'h04;
      write_register_i = 5'd8;
      tick();
      ctrl_i = 8'h01;
      uses_rt_i = 0;
      rt_i = 5'd8;
      rs_i = 5'd9;
      #1;
      check("lu_rt_unused", hazard_o, 1'b0);
      uses_rt_i = 1;
      #1;
      check("lu_rt_used", hazard_o, 1'b1);
      uses_rt_i = 0;
      tick();

      ctrl_i = 8'h04;
      write_register_i = 5'd0;
      tick();
      rs_i = 5'd0;
      rt_i = 5'd0;
      uses_rt_i = 1;
      #1;
      check("lu_r0", hazard_o, 1'b0);
      tick();

      clear_in();
      flush_i = 1;
      stall_i = 1;
      tick();
      check("fl_stall_cnt", bubble_count_o, 16'd1);
      stall_i = 0;
      tick();
      check("fl_cnt", bubble_count_o, 16'd2);
      for (int i = 0; i < 20; i++) tick();
      check("sat4", s_count, 4'hF);

      for (int i = 0; i < 400; i++) begin
         rand_in();
         reset = $urandom_range(0, 63) == 0;
         stall_i = $urandom_range(0, 7) == 0;
         flush_i = $urandom_range(0, 9) == 0;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
